// File: rtl/ram64_arbiter_pkg.sv
// Shared types and defaults for the RAM64 sequencer / two-port arbiter.
package ram64_arbiter_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int ADDR_W_DEF = 6;

  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_IDLE  = 2'd1,
    ST_SERVE = 2'd2
  } state_t;

  typedef enum logic {
    GNT_A = 1'b0,
    GNT_B = 1'b1
  } gnt_t;

endpackage

// File: rtl/ram64_arbiter_rr_arb2.sv
// Two-requester round-robin picker; remembers which side won last.
module rr_arb2
  import ram64_arbiter_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic elig_a,
  input  logic elig_b,
  input  logic advance,
  output logic gnt_a,
  output logic gnt_b
);

  gnt_t last_q, last_d;

  always_comb begin
    // On a tie the side opposite to the last winner goes first.
    gnt_a  = elig_a && (!elig_b || (last_q == GNT_B));
    gnt_b  = elig_b && (!elig_a || (last_q == GNT_A));
    last_d = last_q;
    if (advance && gnt_a) begin
      last_d = GNT_A;
    end else if (advance && gnt_b) begin
      last_d = GNT_B;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_q <= GNT_B;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/ram64_arbiter.sv
// Front-end for one RAM64: optional zero-fill after reset, then
// single-word req/ack accesses from ports A and B, round-robin arbitrated.
//
//   state    | meaning
//   ST_CLEAR | writing zero to address cnt_q, one word per cycle
//   ST_IDLE  | RAM untouched, picking an eligible requester
//   ST_SERVE | granted port drives the RAM; ack and rdata land at cycle end
module ram64_arbiter
  import ram64_arbiter_pkg::*;
#(
  parameter int DATA_W         = DATA_W_DEF,
  parameter int ADDR_W         = ADDR_W_DEF,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_ack,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_ack,
  output logic [DATA_W-1:0] b_rdata,
  output logic [DATA_W-1:0] ram_in,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_load,
  input  logic [DATA_W-1:0] ram_out,
  output logic              busy
);

  state_t            state_q, state_d;
  gnt_t              grant_q, grant_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              a_ack_q, a_ack_d, b_ack_q, b_ack_d;
  logic [DATA_W-1:0] a_rdata_q, a_rdata_d, b_rdata_q, b_rdata_d;
  logic              busy_q, busy_d;
  logic              elig_a, elig_b, gnt_a, gnt_b, advance;

  // A port still showing its ack is skipped so a lingering req is not served twice.
  assign elig_a = a_req && !a_ack_q && (state_q == ST_IDLE);
  assign elig_b = b_req && !b_ack_q && (state_q == ST_IDLE);

  rr_arb2 u_rr_arb2 (
    .clk     (clk),
    .reset   (reset),
    .elig_a  (elig_a),
    .elig_b  (elig_b),
    .advance (advance),
    .gnt_a   (gnt_a),
    .gnt_b   (gnt_b)
  );

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    cnt_d     = cnt_q;
    a_ack_d   = 1'b0;
    b_ack_d   = 1'b0;
    a_rdata_d = a_rdata_q;
    b_rdata_d = b_rdata_q;
    ram_in    = '0;
    ram_addr  = '0;
    ram_load  = 1'b0;
    advance   = 1'b0;
    case (state_q)
      ST_CLEAR: begin
        ram_load = 1'b1;
        ram_addr = cnt_q;
        cnt_d    = cnt_q + ADDR_W'(1);
        if (cnt_q == {ADDR_W{1'b1}}) begin
          state_d = ST_IDLE;
        end
      end
      ST_IDLE: begin
        if (gnt_a || gnt_b) begin
          advance = 1'b1;
          grant_d = gnt_a ? GNT_A : GNT_B;
          state_d = ST_SERVE;
        end
      end
      ST_SERVE: begin
        // ram_out is sampled before the write lands, so writes return the old word.
        if (grant_q == GNT_A) begin
          ram_addr  = a_addr;
          ram_in    = a_wdata;
          ram_load  = a_we;
          a_rdata_d = ram_out;
          a_ack_d   = 1'b1;
        end else begin
          ram_addr  = b_addr;
          ram_in    = b_wdata;
          ram_load  = b_we;
          b_rdata_d = ram_out;
          b_ack_d   = 1'b1;
        end
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d == ST_CLEAR);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      if (CLEAR_ON_RESET != 0) begin
        state_q <= ST_CLEAR;
        busy_q  <= 1'b1;
      end else begin
        state_q <= ST_IDLE;
        busy_q  <= 1'b0;
      end
      grant_q   <= GNT_A;
      cnt_q     <= '0;
      a_ack_q   <= 1'b0;
      b_ack_q   <= 1'b0;
      a_rdata_q <= '0;
      b_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      busy_q    <= busy_d;
      grant_q   <= grant_d;
      cnt_q     <= cnt_d;
      a_ack_q   <= a_ack_d;
      b_ack_q   <= b_ack_d;
      a_rdata_q <= a_rdata_d;
      b_rdata_q <= b_rdata_d;
    end
  end

  assign a_ack   = a_ack_q;
  assign b_ack   = b_ack_q;
  assign a_rdata = a_rdata_q;
  assign b_rdata = b_rdata_q;
  assign busy    = busy_q;

endmodule

// File: doc/ram64_arbiter.md
Name: ram64_arbiter

Overview:
- Sequencer and two-port round-robin arbiter placed in front of one RAM64 (64 x 16-bit, combinational read, write on clk edge when load=1).
- After reset it optionally zero-fills all 64 words.
- It then serves single-word read/write requests from requesters A and B using a req/ack handshake.
- It drives RAM64's in/addr/load and samples its out; it does not instantiate RAM64.

Parameters:
- DATA_W, 16, data width; must match RAM64.
- ADDR_W, 6, address width; the RAM holds 2^ADDR_W words.
- CLEAR_ON_RESET, 1, 1 = zero-fill the RAM after reset; 0 = go straight to IDLE.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- a_req  in  1  A request; held with a_we, a_addr, a_wdata stable until a_ack.
- a_we  in  1  1 = write, 0 = read.
- a_addr  in  ADDR_W  A word address.
- a_wdata  in  DATA_W  A write data.
- a_ack  out  1  one-cycle completion pulse for A.
- a_rdata  out  DATA_W  word read for A; valid while a_ack=1, held afterwards.
- b_req, b_we, b_addr, b_wdata, b_ack, b_rdata: same as A, for requester B.
- ram_in  out  DATA_W  to RAM64 in.
- ram_addr  out  ADDR_W  to RAM64 addr.
- ram_load  out  1  to RAM64 load.
- ram_out  in  DATA_W  from RAM64 out.
- busy  out  1  high while clearing.

Behaviour:
- States: CLEAR, IDLE, SERVE. A grant register (A/B) and a last-granted pointer are kept.
- Reset, sampled at the clk edge:
  - State becomes CLEAR if CLEAR_ON_RESET=1, else IDLE.
  - Clear counter = 0; a_ack = b_ack = 0; a_rdata = b_rdata = 0; last = B, so A wins the first tie.
  - Reset mid-operation abandons any SERVE without ack and restarts the clear.
- CLEAR:
  - ram_load=1, ram_addr=counter, ram_in=0, busy=1.
  - Counter increments each cycle. After the cycle with counter=63 the state goes to IDLE; the clear takes exactly 64 cycles.
  - Requests are ignored and no ack is issued.
- IDLE:
  - ram_load=0, ram_addr=0, ram_in=0.
  - A port is eligible if its req=1 and its ack=0. The ack=0 rule stops a req still high in the ack cycle being served twice.
  - One eligible port: grant it. Both eligible: grant the port opposite to last. Then go to SERVE and update last.
  - None eligible: stay in IDLE.
- SERVE:
  - ram_addr = granted addr, ram_in = granted wdata, ram_load = granted we.
  - At the end of the cycle the granted port's rdata <= ram_out, its ack <= 1, and the state goes to IDLE.
  - Writes therefore return the old contents (read-before-write); the RAM updates at the same edge.
- ack is high for exactly one cycle: the cycle after SERVE.
- Latency: req seen in IDLE at cycle N, SERVE at N+1, ack at N+2.
- Peak throughput is one access per 2 cycles. With both requesting continuously, grants alternate A,B,A,B.
- The ungranted port's inputs never reach the RAM. Only the granted port's ack and rdata change.
- ram_* outputs are combinational from the state, grant register and counter. All other outputs are registered.

Decomposition:
- Shared package: DATA_W/ADDR_W defaults, state encoding constants (ST_CLEAR, ST_IDLE, ST_SERVE), grant encoding (GNT_A, GNT_B).
- One natural sub-module: rr_arb2, the two-requester round-robin picker.
  - Inputs: elig_a, elig_b, advance. Holds the last-granted pointer.
  - Outputs: gnt_a, gnt_b.

Test Plan:
- Clear: assert reset 1 cycle with CLEAR_ON_RESET=1 -> busy=1 for 64 cycles; ram_load=1 with addresses 0..63 and ram_in=0; then IDLE with busy=0. Then A reads addr 63 -> a_rdata=0.
- Write then read: A writes 16'hBEEF to addr 12 -> a_ack at N+2 with a_rdata=0 (old value). A then reads addr 12 -> a_rdata=16'hBEEF.
- Simultaneous requests: A and B both req in the same IDLE cycle after reset -> A is served first (ack at N+2), B next (ack at N+4). Hold both reqs 8 accesses -> grants alternate strictly.
- Hold-through-ack: A keeps a_req=1 one cycle past a_ack -> exactly one SERVE for that request; no second ack.
- Requests during clear: B requests at cycle 5 of the clear -> no ack until after the clear; first b_ack 2 cycles after IDLE is entered.
- Reset mid-SERVE: assert reset during A's SERVE cycle -> a_ack never pulses; a_rdata=0; the clear restarts from addr 0.
